ad5243_readback: RTL and testbench
==================================

Name: ad5243_readback

Overview:
- I2C master read engine that fetches both RDAC wiper bytes from the AD5243 digital potentiometer on the shared HV_SDA/HV_SCL bus.
- Complements the existing write path: the firmware-side controller triggers a readback after a write and gets a 16-bit result plus an ACK error flag.
- Sits beside the write engine; the two are arbitrated upstream and never start at the same time.

Parameters:
- QTR_CNT, 63, clk cycles per quarter SCL bit (100 MHz / (4*63) ≈ 397 kHz, ≤400 kHz).
- DEV_ADDR, 7'h2F, 7-bit AD5243 address; the address byte on the wire is {DEV_ADDR,1'b1} = 8'h5F.

Ports:
- clk  input  1  100 MHz system clock.
- reset_n  input  1  reset: synchronous, active-low.
- rd_start  input  1  one-cycle request pulse; accepted only in IDLE.
- AD_sample_en  input  1  ADC sampling active; SCL must stay quiet (see Behaviour).
- HV_SDA  inout  1  open-drain data: drive 0 or release to 1'bz; external pull-up.
- HV_SCL  output  1  I2C clock, push-pull, idles 1.
- rd_data  output  16  [15:8] = first byte received (channel 2), [7:0] = second byte (channel 1).
- rd_valid  output  1  one-cycle pulse; rd_data is updated on the same cycle.
- busy  output  1  high from start acceptance through the end of STOP.
- ack_err  output  1  sticky; set when the slave NACKs the address; cleared by the next accepted rd_start.

Behaviour:
- Reset values: HV_SCL=1, HV_SDA released, rd_data=16'h0000, rd_valid=0, busy=0, ack_err=0, state=IDLE, qcnt=0.
- Bit timing:
  - qcnt counts 0..QTR_CNT-1; each wrap advances the quarter index q (0..3).
  - q0: SCL=0; the master changes SDA here.
  - q1, q2: SCL=1. Sample SDA on the last clk of q1.
  - q3: SCL=0.
- Start acceptance: rd_start is taken only if state==IDLE and AD_sample_en==0. Otherwise it is dropped, with no queueing.
- Accepted start: busy=1 on the next cycle; ack_err cleared.
- States and transitions:
  - IDLE: SCL=1, SDA released.
  - START: SDA=0 for 2 quarters with SCL=1, then SCL=0 for 1 quarter.
  - ADDR: shift 8'h5F out MSB first, 8 bits.
  - AACK: release SDA and sample. 1 -> set ack_err, go to STOP. 0 -> RD0.
  - RD0: release SDA, shift in 8 bits MSB first.
  - MACK: drive SDA=0 for 1 bit.
  - RD1: shift in 8 bits.
  - MNACK: release SDA (NACK) for 1 bit.
  - STOP: SDA=0 with SCL=0 for 1 quarter, SCL=1 for 1 quarter, then release SDA and hold 1 quarter.
  - DONE: 1 cycle. Load rd_data = {byte0, byte1}, pulse rd_valid, busy=0, go to IDLE.
- NACK path: STOP goes straight to IDLE, busy drops, rd_valid stays 0, rd_data is unchanged.
- Latency from acceptance to rd_valid: 4*QTR_CNT*29 + 1 clks ±1 quarter. The bench checks the window 7300..7320 clks at the default QTR_CNT.
- AD_sample_en asserted mid-transfer:
  - qcnt freezes only at the q0 boundary (SCL=0, SDA stable) and stays frozen until AD_sample_en=0, then resumes.
  - A freeze never occurs with SCL high. START and STOP quarters complete before a freeze is honoured.
- rd_start while busy: ignored; busy, ack_err and rd_data are unaffected.
- Reset low mid-transfer (any state): next clk returns all outputs to reset values and SDA is released. No STOP is generated; the slave recovers on the next START.

Optional Feature:
- Macro RB_COMPARE_EN.
- When defined:
  - Adds input exp_data[15:0] and output cmp_err (reset 0).
  - On the DONE cycle, cmp_err <= (rd_data_next != exp_data).
  - cmp_err holds until the next rd_valid or reset.
  - exp_data is sampled at start acceptance.
- When undefined: neither port exists, and there is no comparator logic or register.

Test Plan:
- Slave model ACKs 8'h5F and returns 8'hA5 then 8'h3C:
  - Check the SCL period = 252 clks and the SDA sequence 0101_1111.
  - Check master ACK after byte 1 and NACK after byte 2.
  - Required: rd_data=16'hA53C, rd_valid pulses once, busy falls on the same cycle.
- Slave NACKs the address -> ack_err=1, STOP generated, rd_valid never asserts, rd_data keeps its prior value; the next accepted rd_start clears ack_err.
- Pulse rd_start at several points during an active read -> ignored. A second pulse after busy falls starts a new transfer returning 16'h0808.
- Assert AD_sample_en for 1000 clks mid RD0 -> SCL held 0 with no edges, transfer resumes, result still correct.
- Also: rd_start while AD_sample_en=1 -> no START generated.
- Drop reset_n for one clk during RD1 -> next clk HV_SCL=1, SDA released, busy=0, rd_data=0. A fresh read then completes normally.
- With RB_COMPARE_EN: exp_data=16'hA53C gives cmp_err=0. exp_data=16'hA53D gives cmp_err=1 on the rd_valid cycle.

Source files
------------

// File: rtl/ad5243_readback.sv
// ad5243_readback: I2C master read engine fetching both AD5243 RDAC wiper bytes.
// Optional comparator against an expected value is enabled by defining RB_COMPARE_EN.
// Every bus phase, START and STOP included, is one 4-quarter bit, so a full read is 29 bits.
module ad5243_readback #(
   parameter int         QTR_CNT  = 63,
   parameter logic [6:0] DEV_ADDR = 7'h2F
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        rd_start,
   input  logic        AD_sample_en,
   inout  wire         HV_SDA,
   output logic        HV_SCL,
   output logic [15:0] rd_data,
   output logic        rd_valid,
   output logic        busy,
   output logic        ack_err
`ifdef RB_COMPARE_EN
   ,
   input  logic [15:0] exp_data,
   output logic        cmp_err
`endif
);
   typedef enum logic [3:0] {
      S_IDLE, S_START, S_ADDR, S_AACK, S_RD0, S_MACK, S_RD1, S_MNACK, S_STOP, S_DONE
   } state_t;

   localparam int            QW        = (QTR_CNT > 1) ? $clog2(QTR_CNT) : 1;
   localparam logic [QW-1:0] QLAST     = QW'(QTR_CNT - 1);
   localparam logic [7:0]    ADDR_BYTE = {DEV_ADDR, 1'b1};

   state_t        r_state;
   state_t        w_next;
   logic [QW-1:0] r_qcnt;
   logic [1:0]    r_q;
   logic [2:0]    r_bit;
   logic [7:0]    r_shift;
   logic [7:0]    r_byte0;
   logic          w_data_st;
   logic          w_hold;
   logic          w_qend;
   logic          w_bend;
   logic          w_accept;
   logic          w_sample;
   logic          w_sda_low;

   // Freezes are only honoured at the first clk of a data bit, where SCL is low and SDA already settled
   assign w_data_st = r_state inside {S_ADDR, S_AACK, S_RD0, S_MACK, S_RD1, S_MNACK};
   assign w_hold    = AD_sample_en && w_data_st && r_q == 2'd0 && r_qcnt == '0;
   assign w_qend    = !w_hold && r_qcnt == QLAST;
   assign w_bend    = w_qend && r_q == 2'd3;
   assign w_accept  = r_state == S_IDLE && rd_start && !AD_sample_en;
   assign w_sample  = w_qend && r_q == 2'd1 && r_state inside {S_AACK, S_RD0, S_RD1};
   assign HV_SDA    = w_sda_low ? 1'b0 : 1'bz;

   // State register
   always_ff @(posedge clk) begin
      r_state <= !reset_n ? S_IDLE : w_next;
   end

   // Next state: phases advance on bit boundaries; a NACKed address skips to STOP and then IDLE
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = S_START;
         S_START: if (w_bend) w_next = S_ADDR;
         S_ADDR:  if (w_bend && r_bit == 3'd7) w_next = S_AACK;
         S_AACK:  if (w_bend) w_next = r_shift[0] ? S_STOP : S_RD0;
         S_RD0:   if (w_bend && r_bit == 3'd7) w_next = S_MACK;
         S_MACK:  if (w_bend) w_next = S_RD1;
         S_RD1:   if (w_bend && r_bit == 3'd7) w_next = S_MNACK;
         S_MNACK: if (w_bend) w_next = S_STOP;
         S_STOP:  if (w_bend) w_next = ack_err ? S_IDLE : S_DONE;
         default: w_next = S_IDLE;
      endcase
   end

   // Bus pins and status flags decoded from state, quarter and bit index
   always_comb begin
      HV_SCL    = w_data_st ? (r_q[0] ^ r_q[1]) :
                  (r_state == S_START) ? (r_q != 2'd3) :
                  (r_state == S_STOP) ? (r_q != 2'd0) : 1'b1;
      w_sda_low = (r_state == S_START) ? (r_q != 2'd0) :
                  (r_state == S_STOP) ? !r_q[1] :
                  (r_state == S_MACK) ? 1'b1 :
                  (r_state == S_ADDR) ? !ADDR_BYTE[~r_bit] : 1'b0;
      rd_valid  = r_state == S_DONE;
      busy      = !(r_state inside {S_IDLE, S_DONE});
   end

   // Quarter timing, bit counting, shift register and result/flag registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_qcnt  <= '0;
         r_q     <= 2'd0;
         r_bit   <= 3'd0;
         r_shift <= 8'h00;
         r_byte0 <= 8'h00;
         rd_data <= 16'h0000;
         ack_err <= 1'b0;
      end else begin
         r_qcnt  <= (r_state == S_IDLE || r_state == S_DONE) ? '0 : w_hold ? r_qcnt : w_qend ? '0 : r_qcnt + 1'b1;
         r_q     <= (r_state == S_IDLE || r_state == S_DONE) ? 2'd0 : w_qend ? r_q + 2'd1 : r_q;
         r_bit   <= (w_bend && r_state inside {S_ADDR, S_RD0, S_RD1}) ? r_bit + 3'd1 : r_bit;
         r_shift <= w_sample ? {r_shift[6:0], HV_SDA} : r_shift;
         r_byte0 <= (r_state == S_RD0 && w_next == S_MACK) ? r_shift : r_byte0;
         rd_data <= (w_next == S_DONE) ? {r_byte0, r_shift} : rd_data;
         ack_err <= w_accept ? 1'b0 : (r_state == S_AACK && w_bend && r_shift[0]) ? 1'b1 : ack_err;
      end
   end

`ifdef RB_COMPARE_EN
   logic [15:0] r_exp;

   // Expected value captured at acceptance; compared as the result is loaded
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_exp   <= 16'h0000;
         cmp_err <= 1'b0;
      end else begin
         r_exp   <= w_accept ? exp_data : r_exp;
         cmp_err <= (w_next == S_DONE) ? ({r_byte0, r_shift} != r_exp) : cmp_err;
      end
   end
`endif
endmodule

// File: tb/tb_ad5243_readback.sv
// tb_ad5243_readback: directed bench for ad5243_readback with a behavioural AD5243 slave.
module tb_ad5243_readback;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        rd_start = 1'b0;
   logic        ad_en = 1'b0;
   wire         hv_sda;
   logic        hv_scl;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic        busy;
   logic        ack_err;
`ifdef RB_COMPARE_EN
   logic [15:0] exp_data = 16'h0000;
   logic        cmp_err;
`endif

   int n_chk = 0;
   int n_fail = 0;

   logic [15:0] slv_data = 16'h0000;
   logic        slv_ack = 1'b1;
   logic        slv_low = 1'b0;
   logic        scl_q = 1'b1;
   logic        sda_q = 1'b1;
   logic [31:0] sda_log = '0;
   int          slv_fall = 0;
   int          slv_rise = 0;
   int          starts = 0;
   int          stops = 0;
   int          nvalid = 0;
   int          cyc_ctr = 0;
   int          last_rise = 0;
   int          scl_per = 0;
   int          nf;
   int          nr;

   always #5 clk = ~clk;

   pullup (hv_sda);
   assign hv_sda = slv_low ? 1'b0 : 1'bz;
   assign nf = slv_fall + 1;
   assign nr = slv_rise + 1;

   ad5243_readback dut (
      .clk(clk), .reset_n(reset_n), .rd_start(rd_start), .AD_sample_en(ad_en),
      .HV_SDA(hv_sda), .HV_SCL(hv_scl), .rd_data(rd_data), .rd_valid(rd_valid),
      .busy(busy), .ack_err(ack_err)
`ifdef RB_COMPARE_EN
      , .exp_data(exp_data), .cmp_err(cmp_err)
`endif
   );

   // Slave: logs SDA at each SCL rise, drives ACK/data after SCL falls, counts START/STOP
   always @(posedge clk) begin
      cyc_ctr <= cyc_ctr + 1;
      scl_q   <= hv_scl;
      sda_q   <= hv_sda;
      if (scl_q && hv_scl && sda_q && !hv_sda) begin
         starts   <= starts + 1;
         slv_fall <= 0;
         slv_rise <= 0;
         slv_low  <= 1'b0;
      end else if (scl_q && hv_scl && !sda_q && hv_sda) begin
         stops <= stops + 1;
      end else if (!scl_q && hv_scl) begin
         slv_rise <= nr;
         if (nr < 32) sda_log[nr] <= hv_sda;
         if (nr == 5) scl_per <= cyc_ctr - last_rise;
         last_rise <= cyc_ctr;
      end else if (scl_q && !hv_scl) begin
         slv_fall <= nf;
         slv_low  <= (nf == 9) ? slv_ack :
                     (slv_ack && nf >= 10 && nf <= 17) ? !slv_data[25 - nf] :
                     (slv_ack && nf >= 19 && nf <= 26) ? !slv_data[26 - nf] : 1'b0;
      end
   end

   always @(negedge clk) if (rd_valid) nvalid <= nvalid + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic read_xfer(input logic [15:0] data, input logic ack, input int inj, input int frz,
                            output int cyc, output logic got);
      int   edges;
      logic sp;
      slv_data = data;
      slv_ack  = ack;
      @(posedge clk); #1 rd_start = 1'b1;
      @(posedge clk); #1 rd_start = 1'b0;
      cyc   = 1;
      edges = 0;
      sp    = hv_scl;
      chk("busy_rise", busy, 1);
      chk("ack_clr", ack_err, 0);
      while (!rd_valid && busy && cyc < 20000) begin
         @(posedge clk); #1 cyc++;
         rd_start = inj != 0 && (cyc == 100 || cyc == 3000 || cyc == 6000);
         if (inj != 0 && cyc == 101) chk("inj_busy", busy, 1);
         if (frz != 0) ad_en = cyc >= frz && cyc < frz + 1000;
         if (frz != 0 && cyc == frz + 175) chk("frz_scl_low", hv_scl, 0);
         if (frz != 0 && cyc >= frz + 175 && cyc < frz + 975 && hv_scl !== sp) edges++;
         sp = hv_scl;
      end
      rd_start = 1'b0;
      ad_en    = 1'b0;
      got      = rd_valid;
      chk("xfer_end", cyc < 20000, 1);
      if (frz != 0) chk("frz_edges", edges, 0);
   endtask

   initial begin
      int          cyc;
      logic        got;
      int          s0, p0, v0;
      logic [7:0]  a;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_scl", hv_scl, 1);
      chk("rst_sda", hv_sda, 1);
      chk("rst_data", rd_data, 16'h0000);
      chk("rst_valid", rd_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ackerr", ack_err, 0);
`ifdef RB_COMPARE_EN
      chk("rst_cmp", cmp_err, 0);
      exp_data = 16'hA53C;
`endif
      reset_n = 1'b1;
      repeat (2) @(posedge clk);

      s0 = starts; p0 = stops; v0 = nvalid;
      read_xfer(16'hA53C, 1'b1, 0, 0, cyc, got);
      chk("t1_valid", got, 1);
      chk("t1_data", rd_data, 16'hA53C);
      chk("t1_busy_fall", busy, 0);
      chk("t1_latency_window", cyc >= 7300 && cyc <= 7320, 1);
`ifdef RB_COMPARE_EN
      chk("t1_cmp", cmp_err, 0);
`endif
      for (int i = 0; i < 8; i++) a[7-i] = sda_log[i+1];
      chk("t1_addr", a, 8'h5F);
      chk("t1_aack", sda_log[9], 0);
      chk("t1_mack", sda_log[18], 0);
      chk("t1_mnack", sda_log[27], 1);
      chk("t1_scl_per", scl_per, 252);
      @(posedge clk); #1;
      chk("t1_valid_pulse", rd_valid, 0);
      chk("t1_nvalid", nvalid - v0, 1);
      chk("t1_starts", starts - s0, 1);
      chk("t1_stops", stops - p0, 1);

      p0 = stops; v0 = nvalid;
      read_xfer(16'h1111, 1'b0, 0, 0, cyc, got);
      repeat (5) @(posedge clk);
      #1;
      chk("nack_valid", got, 0);
      chk("nack_err", ack_err, 1);
      chk("nack_data", rd_data, 16'hA53C);
      chk("nack_aack", sda_log[9], 1);
      chk("nack_stop", stops - p0, 1);
      chk("nack_nvalid", nvalid - v0, 0);
      chk("nack_busy", busy, 0);

      s0 = starts;
      read_xfer(16'h1234, 1'b1, 1, 0, cyc, got);
      chk("inj_valid", got, 1);
      chk("inj_data", rd_data, 16'h1234);
      chk("inj_starts", starts - s0, 1);
      @(posedge clk); #1;
      read_xfer(16'h0808, 1'b1, 0, 0, cyc, got);
      chk("second_valid", got, 1);
      chk("second_data", rd_data, 16'h0808);

      read_xfer(16'h5AC3, 1'b1, 0, 3125, cyc, got);
      chk("frz_valid", got, 1);
      chk("frz_data", rd_data, 16'h5AC3);
      chk("frz_latency_window", cyc >= 8140 && cyc <= 8175, 1);

      ad_en = 1'b1;
      s0 = starts;
      @(posedge clk); #1 rd_start = 1'b1;
      @(posedge clk); #1 rd_start = 1'b0;
      chk("adblk_busy", busy, 0);
      repeat (300) @(posedge clk);
      #1;
      chk("adblk_starts", starts - s0, 0);
      chk("adblk_scl", hv_scl, 1);
      ad_en = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("adblk_noqueue", busy, 0);

`ifdef RB_COMPARE_EN
      exp_data = 16'hA53D;
`endif
      slv_data = 16'hA53C;
      slv_ack  = 1'b1;
      @(posedge clk); #1 rd_start = 1'b1;
      @(posedge clk); #1 rd_start = 1'b0;
      repeat (5418) @(posedge clk);
      #1;
      chk("rstmid_busy_before", busy, 1);
      reset_n = 1'b0;
      @(posedge clk); #1;
      chk("rstmid_scl", hv_scl, 1);
      chk("rstmid_sda", hv_sda, 1);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_data", rd_data, 16'h0000);
      chk("rstmid_valid", rd_valid, 0);
`ifdef RB_COMPARE_EN
      chk("rstmid_cmp", cmp_err, 0);
`endif
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      read_xfer(16'hA53C, 1'b1, 0, 0, cyc, got);
      chk("fresh_valid", got, 1);
      chk("fresh_data", rd_data, 16'hA53C);
`ifdef RB_COMPARE_EN
      chk("fresh_cmp", cmp_err, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
